// File: rtl/hdmi_text_axil_pkg.sv
// Shared constants, FSM state types and address helper for the
// hdmi_text_controller AXI4-Lite register bank.
package hdmi_text_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // Byte address to 32-bit word index; the two byte-lane bits drop out.
    function automatic logic [31:0] word_idx(input logic [31:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/hdmi_text_axil_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the
// text-controller register bank (slave).
interface hdmi_text_axil_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface

// File: rtl/hdmi_text_axil_wslot.sv
// One-entry holding slot for an AXI write channel (AW or W): accepts a beat
// when empty and allowed, holds it until the owner clears it on commit.
module hdmi_text_axil_wslot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             allow,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    input  logic             clear,
    output logic             ready,
    output logic             full,
    output logic [WIDTH-1:0] held
);

    logic             full_r;
    logic [WIDTH-1:0] held_r;

    assign ready = allow && !full_r;
    assign full  = full_r;
    assign held  = held_r;

    // Slot occupancy and captured payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r <= 1'b0;
            held_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            full_r <= 1'b0;
        end else if (valid && ready) begin
            full_r <= 1'b1;
            held_r <= data;
        end
    end

endmodule

// File: rtl/hdmi_text_axil_regs.sv
// AXI4-Lite slave holding the hdmi_text_controller control registers and
// exposing them, plus per-register write strobes, to the render core.
module hdmi_text_axil_regs
    import hdmi_text_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    hdmi_text_axil_if.slave          s_axi,
    output logic [NUM_REGS*32-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);

    localparam int          STRB_W     = C_S_AXI_DATA_WIDTH / 8;
    localparam int          WSLOT_W    = C_S_AXI_DATA_WIDTH + STRB_W;
    localparam logic [31:0] NUM_REGS_U = NUM_REGS;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic                          ready_en_r;
    wstate_t                       wstate_r, wstate_nxt_s;
    rstate_t                       rstate_r, rstate_nxt_s;
    logic                          slot_allow_s, aw_full_s, w_full_s;
    logic                          commit_s, ar_hs_s, arready_s;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_s;
    logic [WSLOT_W-1:0]            w_held_s;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_s;
    logic [STRB_W-1:0]             w_strb_s;
    logic [31:0]                   wr_idx_s, rd_idx_s;
    logic                          wr_in_range_s, rd_in_range_s;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_word_s;
    logic [NUM_REGS-1:0]           pulse_nxt_s;
    logic [1:0]                    bresp_r, rresp_r;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_r;
    logic [NUM_REGS-1:0]           wr_pulse_r;
    logic                          unused_s;

    assign unused_s = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

    // Keeps every READY low through reset and the first cycle after it.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) ready_en_r <= 1'b0;
        else        ready_en_r <= 1'b1;
    end

    assign slot_allow_s = ready_en_r && (wstate_r == W_IDLE);

    hdmi_text_axil_wslot #(.WIDTH(C_S_AXI_ADDR_WIDTH)) u_aw_slot (
        .clk   (ACLK),
        .rst   (ARESET),
        .allow (slot_allow_s),
        .valid (s_axi.S_AXI_AWVALID),
        .data  (s_axi.S_AXI_AWADDR),
        .clear (commit_s),
        .ready (s_axi.S_AXI_AWREADY),
        .full  (aw_full_s),
        .held  (aw_addr_s)
    );

    hdmi_text_axil_wslot #(.WIDTH(WSLOT_W)) u_w_slot (
        .clk   (ACLK),
        .rst   (ARESET),
        .allow (slot_allow_s),
        .valid (s_axi.S_AXI_WVALID),
        .data  ({s_axi.S_AXI_WSTRB, s_axi.S_AXI_WDATA}),
        .clear (commit_s),
        .ready (s_axi.S_AXI_WREADY),
        .full  (w_full_s),
        .held  (w_held_s)
    );

    assign w_data_s      = w_held_s[C_S_AXI_DATA_WIDTH-1:0];
    assign w_strb_s      = w_held_s[WSLOT_W-1:C_S_AXI_DATA_WIDTH];
    assign commit_s      = aw_full_s && w_full_s && (wstate_r == W_IDLE);
    assign wr_idx_s      = word_idx(32'(aw_addr_s));
    assign wr_in_range_s = wr_idx_s < NUM_REGS_U;

    // Byte-lane register update on commit.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_REGS; k++) regs_r[k] <= {C_S_AXI_DATA_WIDTH{1'b0}};
        end else if (commit_s && wr_in_range_s) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if ((wr_idx_s == 32'(k)) && w_strb_s[b]) begin
                        regs_r[k][8*b +: 8] <= w_data_s[8*b +: 8];
                    end
                end
            end
        end
    end

    // Write FSM state register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) wstate_r <= W_IDLE;
        else        wstate_r <= wstate_nxt_s;
    end

    // Write FSM next state and strobe decode.
    always_comb begin
        wstate_nxt_s = wstate_r;
        pulse_nxt_s  = {NUM_REGS{1'b0}};
        case (wstate_r)
            W_IDLE: begin
                if (commit_s) wstate_nxt_s = W_RESP;
                else          wstate_nxt_s = W_IDLE;
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) wstate_nxt_s = W_IDLE;
                else                    wstate_nxt_s = W_RESP;
            end
            default: wstate_nxt_s = W_IDLE;
        endcase
        for (int k = 0; k < NUM_REGS; k++) begin
            if (commit_s && wr_in_range_s && (wr_idx_s == 32'(k))) pulse_nxt_s[k] = 1'b1;
            else                                                   pulse_nxt_s[k] = 1'b0;
        end
    end

    // Write response and one-cycle write strobes.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            bresp_r    <= 2'b00;
            wr_pulse_r <= {NUM_REGS{1'b0}};
        end else begin
            wr_pulse_r <= pulse_nxt_s;
            if (commit_s) bresp_r <= wr_in_range_s ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign arready_s     = ready_en_r && (rstate_r == R_IDLE);
    assign ar_hs_s       = s_axi.S_AXI_ARVALID && arready_s;
    assign rd_idx_s      = word_idx(32'(s_axi.S_AXI_ARADDR));
    assign rd_in_range_s = rd_idx_s < NUM_REGS_U;

    // Read mux; sees the pre-commit value when a write lands in the same cycle.
    always_comb begin
        rd_word_s = {C_S_AXI_DATA_WIDTH{1'b0}};
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_idx_s == 32'(k)) rd_word_s = regs_r[k];
            else                    rd_word_s = rd_word_s;
        end
    end

    // Read FSM state register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) rstate_r <= R_IDLE;
        else        rstate_r <= rstate_nxt_s;
    end

    // Read FSM next state.
    always_comb begin
        rstate_nxt_s = rstate_r;
        case (rstate_r)
            R_IDLE: begin
                if (ar_hs_s) rstate_nxt_s = R_DATA;
                else         rstate_nxt_s = R_IDLE;
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) rstate_nxt_s = R_IDLE;
                else                    rstate_nxt_s = R_DATA;
            end
            default: rstate_nxt_s = R_IDLE;
        endcase
    end

    // Read data/response capture, held until RREADY.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rdata_r <= {C_S_AXI_DATA_WIDTH{1'b0}};
            rresp_r <= 2'b00;
        end else if (ar_hs_s) begin
            rdata_r <= rd_in_range_s ? rd_word_s : {C_S_AXI_DATA_WIDTH{1'b0}};
            rresp_r <= rd_in_range_s ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign s_axi.S_AXI_BVALID  = (wstate_r == W_RESP);
    assign s_axi.S_AXI_BRESP   = bresp_r;
    assign s_axi.S_AXI_ARREADY = arready_s;
    assign s_axi.S_AXI_RVALID  = (rstate_r == R_DATA);
    assign s_axi.S_AXI_RDATA   = rdata_r;
    assign s_axi.S_AXI_RRESP   = rresp_r;
    assign wr_pulse_o          = wr_pulse_r;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs_o[32*k +: 32] = regs_r[k];
    end

endmodule

// File: tb/tb_hdmi_text_axil_regs.sv
// Scoreboard bench for hdmi_text_axil_regs: expected B/R responses are queued
// when stimulus is issued and compared when the DUT handshakes them.
module tb_hdmi_text_axil_regs;
    import hdmi_text_axil_pkg::*;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic [127:0] regs_o;
    logic [3:0]   wr_pulse_o;

    exp_t         bq[$];
    exp_t         rq[$];
    logic [31:0]  model[4];
    int           tests_run = 0;
    int           tests_failed = 0;
    int           b_count = 0;
    int           r_count = 0;
    logic         bvalid_prev = 1'b0;
    logic         pulse_clr_pending = 1'b0;

    hdmi_text_axil_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

    hdmi_text_axil_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(6),
        .NUM_REGS(4)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .s_axi      (bus.slave),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: handshakes seen at negedge complete on the next posedge.
    always @(negedge ACLK) begin
        exp_t e;
        if (pulse_clr_pending) begin
            check("wr_pulse_clr", 32'(wr_pulse_o), 32'h0);
            pulse_clr_pending = 1'b0;
        end
        if (bus.S_AXI_BVALID && !bvalid_prev) begin
            if (bq.size() > 0) check("wr_pulse", 32'(wr_pulse_o), bq[0].data);
            pulse_clr_pending = 1'b1;
        end
        bvalid_prev = bus.S_AXI_BVALID;
        if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
            if (bq.size() == 0) begin
                check("b_extra", 32'(bq.size()), 32'h1);
            end else begin
                e = bq.pop_front();
                check("bresp", 32'(bus.S_AXI_BRESP), 32'(e.resp));
            end
            b_count++;
        end
        if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
            if (rq.size() == 0) begin
                check("r_extra", 32'(rq.size()), 32'h1);
            end else begin
                e = rq.pop_front();
                check("rresp", 32'(bus.S_AXI_RRESP), 32'(e.resp));
                check("rdata", bus.S_AXI_RDATA, e.data);
            end
            r_count++;
        end
    end

    function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] strb);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic check_regs(input string tag);
        for (int k = 0; k < 4; k++) check(tag, regs_o[32*k +: 32], model[k]);
    endtask

    task automatic wait_b(input int target);
        int n = 0;
        while (b_count < target && n < 60) begin
            @(posedge ACLK);
            n++;
        end
        if (b_count < target) check("b_timeout", 32'(b_count), 32'(target));
        #1;
    endtask

    task automatic wait_r(input int target);
        int n = 0;
        while (r_count < target && n < 60) begin
            @(posedge ACLK);
            n++;
        end
        if (r_count < target) check("r_timeout", 32'(r_count), 32'(target));
        #1;
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic do_wait);
        exp_t e;
        int   idx = int'(addr >> 2);
        logic aw_done = 1'b0;
        logic w_done = 1'b0;
        int   n = 0;
        int   target = b_count + bq.size() + 1;
        e.resp = (idx < 4) ? RESP_OKAY : RESP_SLVERR;
        e.data = (idx < 4) ? (32'h1 << idx) : 32'h0;
        if (idx < 4) model[idx] = apply_strb(model[idx], data, strb);
        bq.push_back(e);
        @(posedge ACLK); #1;
        bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = data;  bus.S_AXI_WSTRB = strb; bus.S_AXI_WVALID = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            @(negedge ACLK);
            if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) aw_done = 1'b1;
            if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) w_done = 1'b1;
            @(posedge ACLK); #1;
            if (aw_done) bus.S_AXI_AWVALID = 1'b0;
            if (w_done) bus.S_AXI_WVALID = 1'b0;
            n++;
        end
        if (!(aw_done && w_done)) check("write_accept", 32'({aw_done, w_done}), 32'h3);
        if (do_wait) wait_b(target);
    endtask

    task automatic axi_read(input logic [5:0] addr, input logic do_wait);
        exp_t e;
        int   idx = int'(addr >> 2);
        logic done = 1'b0;
        int   n = 0;
        int   target = r_count + rq.size() + 1;
        e.resp = (idx < 4) ? RESP_OKAY : RESP_SLVERR;
        e.data = (idx < 4) ? model[idx] : 32'h0;
        rq.push_back(e);
        @(posedge ACLK); #1;
        bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
        while (!done && n < 50) begin
            @(negedge ACLK);
            if (bus.S_AXI_ARREADY) done = 1'b1;
            @(posedge ACLK); #1;
            if (done) bus.S_AXI_ARVALID = 1'b0;
            n++;
        end
        if (!done) check("read_accept", 32'(done), 32'h1);
        if (do_wait) wait_r(target);
    endtask

    initial begin
        int n;
        logic [31:0] hold_rdata;
        for (int k = 0; k < 4; k++) model[k] = 32'h0;
        bus.S_AXI_AWADDR = 6'h0; bus.S_AXI_AWPROT = 3'b000; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = 32'h0; bus.S_AXI_WSTRB = 4'h0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_ARADDR = 6'h0; bus.S_AXI_ARPROT = 3'b000; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b1;

        repeat (3) @(posedge ACLK);
        #2;
        check("rst_awready", 32'(bus.S_AXI_AWREADY), 32'h0);
        check("rst_arready", 32'(bus.S_AXI_ARREADY), 32'h0);
        check("rst_bvalid", 32'(bus.S_AXI_BVALID), 32'h0);
        check("rst_rvalid", 32'(bus.S_AXI_RVALID), 32'h0);
        check("rst_pulse", 32'(wr_pulse_o), 32'h0);
        check_regs("rst_regs");
        ARESET = 1'b0;
        repeat (2) @(posedge ACLK);

        // Sequential writes and read-back.
        for (int k = 0; k < 4; k++) axi_write(6'(4 * k), 32'(k + 1), 4'hF, 1'b1);
        check_regs("seq_regs");
        for (int k = 0; k < 4; k++) axi_read(6'(4 * k), 1'b1);

        // W arrives three cycles ahead of AW.
        begin
            exp_t e;
            e.resp = RESP_OKAY; e.data = 32'h2;
            bq.push_back(e);
            @(posedge ACLK); #1;
            bus.S_AXI_WDATA = 32'hDEADBEEF; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
            @(negedge ACLK);
            check("early_wready", 32'(bus.S_AXI_WREADY), 32'h1);
            @(posedge ACLK); #1;
            bus.S_AXI_WVALID = 1'b0;
            repeat (3) begin
                @(negedge ACLK);
                check("early_no_b", 32'(bus.S_AXI_BVALID), 32'h0);
                check("early_reg1_old", regs_o[63:32], model[1]);
                @(posedge ACLK); #1;
            end
            bus.S_AXI_AWADDR = 6'h04; bus.S_AXI_AWVALID = 1'b1;
            @(negedge ACLK);
            check("early_awready", 32'(bus.S_AXI_AWREADY), 32'h1);
            @(posedge ACLK); #1;
            bus.S_AXI_AWVALID = 1'b0;
            @(negedge ACLK);
            check("early_commit_cycle_b", 32'(bus.S_AXI_BVALID), 32'h0);
            @(negedge ACLK);
            check("early_b_after_commit", 32'(bus.S_AXI_BVALID), 32'h1);
            model[1] = 32'hDEADBEEF;
            check("early_reg1_new", regs_o[63:32], model[1]);
            wait_b(b_count + bq.size());
        end

        // Byte strobes.
        axi_write(6'h00, 32'h11223344, 4'hF, 1'b1);
        axi_write(6'h00, 32'hAABBCCDD, 4'b0101, 1'b1);
        check("strb_reg0", regs_o[31:0], 32'h11BB33DD);
        axi_write(6'h08, 32'hFFFFFFFF, 4'b0000, 1'b1);
        check_regs("strb_regs");

        // Out-of-range accesses.
        axi_write(6'h10, 32'hCAFEF00D, 4'hF, 1'b1);
        axi_read(6'h14, 1'b1);
        check_regs("oor_regs");

        // Back-pressure on B.
        bus.S_AXI_BREADY = 1'b0;
        axi_write(6'h0C, 32'h0BADC0DE, 4'hF, 1'b0);
        n = 0;
        while (!bus.S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
        repeat (10) begin
            @(negedge ACLK);
            check("bstall_bvalid", 32'(bus.S_AXI_BVALID), 32'h1);
            check("bstall_bresp", 32'(bus.S_AXI_BRESP), 32'(RESP_OKAY));
            check("bstall_awready", 32'(bus.S_AXI_AWREADY), 32'h0);
            check("bstall_wready", 32'(bus.S_AXI_WREADY), 32'h0);
        end
        @(posedge ACLK); #1;
        bus.S_AXI_BREADY = 1'b1;
        wait_b(b_count + bq.size());

        // Back-pressure on R.
        bus.S_AXI_RREADY = 1'b0;
        axi_read(6'h0C, 1'b0);
        n = 0;
        while (!bus.S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
        hold_rdata = model[3];
        repeat (10) begin
            @(negedge ACLK);
            check("rstall_rvalid", 32'(bus.S_AXI_RVALID), 32'h1);
            check("rstall_rdata", bus.S_AXI_RDATA, hold_rdata);
            check("rstall_rresp", 32'(bus.S_AXI_RRESP), 32'(RESP_OKAY));
            check("rstall_arready", 32'(bus.S_AXI_ARREADY), 32'h0);
        end
        @(posedge ACLK); #1;
        bus.S_AXI_RREADY = 1'b1;
        wait_r(r_count + rq.size());

        // Reset with only AW captured.
        @(posedge ACLK); #1;
        bus.S_AXI_AWADDR = 6'h08; bus.S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        bus.S_AXI_AWVALID = 1'b0;
        #2 ARESET = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) model[k] = 32'h0;
        check("arst_awready", 32'(bus.S_AXI_AWREADY), 32'h0);
        check("arst_wready", 32'(bus.S_AXI_WREADY), 32'h0);
        check("arst_arready", 32'(bus.S_AXI_ARREADY), 32'h0);
        check("arst_bvalid", 32'(bus.S_AXI_BVALID), 32'h0);
        check("arst_rvalid", 32'(bus.S_AXI_RVALID), 32'h0);
        check("arst_rdata", bus.S_AXI_RDATA, 32'h0);
        check("arst_pulse", 32'(wr_pulse_o), 32'h0);
        check_regs("arst_regs");
        repeat (2) @(posedge ACLK);
        #2 ARESET = 1'b0;
        axi_write(6'h08, 32'h5A5A0001, 4'hF, 1'b1);
        check_regs("post_rst_regs");
        axi_read(6'h08, 1'b1);
        axi_read(6'h00, 1'b1);

        repeat (3) @(posedge ACLK);
        check("b_queue_empty", 32'(bq.size()), 32'h0);
        check("r_queue_empty", 32'(rq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
